// File: rtl/rpn_pkg.sv
// Shared types and constants for the RPN calculator stack sequencer.
// Status encoding is one-hot per state; err bits are indexed by the ERR_* constants.
package rpn_pkg;

  localparam int N_DEFAULT   = 16;
  localparam int OPW_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] STATUS_IDLE  = 3'b001;
  localparam logic [2:0] STATUS_ISSUE = 3'b010;
  localparam logic [2:0] STATUS_WAIT  = 3'b100;

  localparam int ERR_UNDER = 0;
  localparam int ERR_OVER  = 1;
  localparam int ERR_TMO   = 2;

  function automatic logic [2:0] state_status(input state_t s);
    case (s)
      IDLE:    return STATUS_IDLE;
      ISSUE:   return STATUS_ISSUE;
      WAIT:    return STATUS_WAIT;
      default: return STATUS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rpn_operand_stack.sv
// Operand storage with a depth counter. Commands: push, pop, and replace (pop two, push one).
// Exposes the top and second entries combinationally; both read 0 when not occupied.
module rpn_operand_stack #(
  parameter int  N     = 16,
  parameter int  DEPTH = 4,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          replace,
  input  logic [N-1:0]  din,
  output logic [N-1:0]  top,
  output logic [N-1:0]  second,
  output logic [DW-1:0] depth
);

  logic [N-1:0]     mem_reg [DEPTH];
  logic [DW-1:0]    depth_reg;
  logic [DW-1:0]    depth_next;
  logic [DEPTH-1:0] wr_en;

  // Push writes slot[depth]; replace writes slot[depth-2] with the ALU result.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_wr
      assign wr_en[gi] = (push && (depth_reg == DW'(gi))) ||
                         (replace && (depth_reg == DW'(gi + 2)));
    end
  endgenerate

  always_comb begin
    depth_next = depth_reg;
    if (push && (depth_reg != DW'(DEPTH)))
      depth_next = depth_reg + DW'(1);
    else if (pop && (depth_reg != '0))
      depth_next = depth_reg - DW'(1);
    else if (replace && (depth_reg >= DW'(2)))
      depth_next = depth_reg - DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_reg[i] <= '0;
      depth_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_en[i])
          mem_reg[i] <= din;
      depth_reg <= depth_next;
    end
  end

  // Constant-index muxes keep the read path free of index-width truncation.
  always_comb begin
    top    = '0;
    second = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_reg == DW'(i + 1))
        top = mem_reg[i];
      if (depth_reg == DW'(i + 2))
        second = mem_reg[i];
    end
  end

  assign depth = depth_reg;

endmodule

// File: rtl/rpn_stack_sequencer.sv
// RPN calculator controller: pushes operands, issues the two top entries to the ALU via a
// start/done handshake, writes the result back, and aborts the transaction on timeout.
module rpn_stack_sequencer
  import rpn_pkg::*;
#(
  parameter int  N       = N_DEFAULT,
  parameter int  DEPTH   = 4,
  parameter int  OPW     = OPW_DEFAULT,
  parameter int  TIMEOUT = 64,
  localparam int DW      = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enter_pulse,
  input  logic           undo_pulse,
  input  logic           op_mode,
  input  logic [N-1:0]   data_in,
  input  logic [N-1:0]   alu_result,
  input  logic           alu_done,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  output logic           alu_start,
  output logic [N-1:0]   tos,
  output logic [DW-1:0]  depth,
  output logic           busy,
  output logic [2:0]     status,
  output logic [2:0]     err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state_reg, state_next;
  logic [CW-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic [2:0]     err_reg, err_next;
  logic [N-1:0]   alu_a_reg, alu_a_next;
  logic [N-1:0]   alu_b_reg, alu_b_next;
  logic [OPW-1:0] alu_op_reg, alu_op_next;

  logic           stk_push, stk_pop, stk_replace;
  logic [N-1:0]   stk_din, stk_top, stk_second;
  logic [DW-1:0]  stk_depth;

  assign stk_din = stk_push ? data_in : alu_result;

  rpn_operand_stack #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (stk_push),
    .pop     (stk_pop),
    .replace (stk_replace),
    .din     (stk_din),
    .top     (stk_top),
    .second  (stk_second),
    .depth   (stk_depth)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      tmo_cnt_reg <= '0;
      err_reg     <= '0;
      alu_a_reg   <= '0;
      alu_b_reg   <= '0;
      alu_op_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      tmo_cnt_reg <= tmo_cnt_next;
      err_reg     <= err_next;
      alu_a_reg   <= alu_a_next;
      alu_b_reg   <= alu_b_next;
      alu_op_reg  <= alu_op_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tmo_cnt_next = tmo_cnt_reg;
    err_next     = err_reg;
    alu_a_next   = alu_a_reg;
    alu_b_next   = alu_b_reg;
    alu_op_next  = alu_op_reg;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    stk_replace  = 1'b0;

    case (state_reg)
      IDLE: begin
        // Undo takes priority over a simultaneous Enter.
        if (undo_pulse) begin
          if (stk_depth != '0) begin
            stk_pop  = 1'b1;
            err_next = '0;
          end else begin
            err_next[ERR_UNDER] = 1'b1;
          end
        end else if (enter_pulse) begin
          if (!op_mode) begin
            if (stk_depth != DW'(DEPTH)) begin
              stk_push = 1'b1;
              err_next = '0;
            end else begin
              err_next[ERR_OVER] = 1'b1;
            end
          end else if (stk_depth < DW'(2)) begin
            err_next[ERR_UNDER] = 1'b1;
          end else begin
            alu_a_next  = stk_second;
            alu_b_next  = stk_top;
            alu_op_next = data_in[OPW-1:0];
            err_next    = '0;
            state_next  = ISSUE;
          end
        end
      end

      ISSUE: begin
        tmo_cnt_next = '0;
        state_next   = WAIT;
      end

      WAIT: begin
        if (alu_done) begin
          stk_replace = 1'b1;
          state_next  = IDLE;
        end else if (tmo_cnt_reg == CW'(TIMEOUT - 1)) begin
          // Operands stay on the stack so the user can retry.
          err_next[ERR_TMO] = 1'b1;
          state_next        = IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + CW'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_op    = alu_op_reg;
  assign alu_start = (state_reg == ISSUE);
  assign tos       = stk_top;
  assign depth     = stk_depth;
  assign busy      = (state_reg != IDLE);
  assign status    = state_status(state_reg);
  assign err       = err_reg;

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Self-checking bench for rpn_stack_sequencer: directed scenarios then random commands,
// checked against a queue-based stack model and a latency-programmable ALU model.
module tb_rpn_stack_sequencer;

  localparam int N       = 16;
  localparam int DEPTH   = 4;
  localparam int OPW     = 2;
  localparam int TIMEOUT = 64;
  localparam int DW      = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           reset;
  logic           enter_pulse, undo_pulse, op_mode;
  logic [N-1:0]   data_in;
  logic [N-1:0]   alu_result;
  logic           alu_done;
  logic [N-1:0]   alu_a, alu_b, tos;
  logic [OPW-1:0] alu_op;
  logic           alu_start, busy;
  logic [DW-1:0]  depth;
  logic [2:0]     status, err;

  int checks   = 0;
  int failures = 0;

  // ALU model state: latency 0 means "never answer".
  int           alu_lat = 2;
  int           alu_cd  = 0;
  logic [N-1:0] alu_res_pend;

  // Reference model.
  logic [N-1:0] q[$];
  logic [2:0]   m_err;

  rpn_stack_sequencer #(
    .N(N), .DEPTH(DEPTH), .OPW(OPW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enter_pulse(enter_pulse), .undo_pulse(undo_pulse),
    .op_mode(op_mode), .data_in(data_in), .alu_result(alu_result), .alu_done(alu_done),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start), .tos(tos),
    .depth(depth), .busy(busy), .status(status), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [OPW-1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  initial begin
    alu_done   = 1'b0;
    alu_result = '0;
    forever begin
      @(posedge clk);
      #1;
      alu_done = 1'b0;
      if (alu_cd > 0) begin
        alu_cd--;
        if (alu_cd == 0) begin
          alu_done   = 1'b1;
          alu_result = alu_res_pend;
        end
      end
      if (alu_start === 1'b1 && alu_lat > 0) begin
        alu_cd       = alu_lat;
        alu_res_pend = alu_f(alu_a, alu_b, alu_op);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    logic [N-1:0] exp_tos;
    exp_tos = (q.size() > 0) ? q[q.size()-1] : '0;
    chk({tag, "/tos"}, 32'(tos), 32'(exp_tos));
    chk({tag, "/depth"}, 32'(depth), 32'(q.size()));
    chk({tag, "/err"}, 32'(err), 32'(m_err));
    chk({tag, "/status"}, 32'(status), 32'b001);
    chk({tag, "/busy"}, 32'(busy), 32'd0);
    chk({tag, "/start"}, 32'(alu_start), 32'd0);
  endtask

  // One command in IDLE; for an accepted operator, follows the transaction to IDLE.
  task automatic cmd(input bit en, input bit un, input bit opm, input logic [N-1:0] d,
                     input int lat, input bit poke, input string tag);
    int             n, starts, waits;
    logic [N-1:0]   ea, eb;
    logic [OPW-1:0] eop;
    alu_lat     = lat;
    enter_pulse = en;
    undo_pulse  = un;
    op_mode     = opm;
    data_in     = d;
    tick();
    enter_pulse = 1'b0;
    undo_pulse  = 1'b0;
    if (un) begin
      if (q.size() > 0) begin
        void'(q.pop_back());
        m_err = 3'b000;
      end else m_err |= 3'b001;
    end else if (en && !opm) begin
      if (q.size() < DEPTH) begin
        q.push_back(d);
        m_err = 3'b000;
      end else m_err |= 3'b010;
    end else if (en) begin
      if (q.size() < 2) m_err |= 3'b001;
      else begin
        ea    = q[q.size()-2];
        eb    = q[q.size()-1];
        eop   = d[OPW-1:0];
        m_err = 3'b000;
        chk({tag, "/issue_status"}, 32'(status), 32'b010);
        chk({tag, "/issue_start"}, 32'(alu_start), 32'd1);
        chk({tag, "/issue_busy"}, 32'(busy), 32'd1);
        chk({tag, "/alu_a"}, 32'(alu_a), 32'(ea));
        chk({tag, "/alu_b"}, 32'(alu_b), 32'(eb));
        chk({tag, "/alu_op"}, 32'(alu_op), 32'(eop));
        n      = 0;
        starts = 0;
        waits  = 0;
        while (busy === 1'b1 && n < TIMEOUT + 10) begin
          tick();
          n++;
          enter_pulse = poke && (n == 1);
          undo_pulse  = poke && (n == 1);
          if (alu_start === 1'b1) starts++;
          if (status === 3'b100) waits++;
        end
        enter_pulse = 1'b0;
        undo_pulse  = 1'b0;
        chk({tag, "/latency"}, 32'(n), (lat > 0) ? 32'(1 + lat) : 32'(1 + TIMEOUT));
        chk({tag, "/wait_cycles"}, 32'(waits), (lat > 0) ? 32'(lat) : 32'(TIMEOUT));
        chk({tag, "/extra_starts"}, 32'(starts), 32'd0);
        if (lat > 0) begin
          void'(q.pop_back());
          void'(q.pop_back());
          q.push_back(alu_f(ea, eb, eop));
        end else m_err = 3'b100;
      end
    end
    check_idle(tag);
    $display("txn %s en=%0b un=%0b op=%0b d=%04h lat=%0d -> tos=%04h depth=%0d err=%03b",
             tag, en, un, opm, d, lat, tos, depth, err);
  endtask

  initial begin
    int r, lat;
    reset       = 1'b1;
    enter_pulse = 1'b0;
    undo_pulse  = 1'b0;
    op_mode     = 1'b0;
    data_in     = '0;
    m_err       = 3'b000;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_idle("reset");
    chk("reset/alu_a", 32'(alu_a), 32'd0);
    chk("reset/alu_b", 32'(alu_b), 32'd0);
    chk("reset/alu_op", 32'(alu_op), 32'd0);

    // Basic add: 5 + 3 with a two-cycle ALU.
    cmd(1, 0, 0, 16'h0005, 2, 0, "push5");
    cmd(1, 0, 0, 16'h0003, 2, 0, "push3");
    cmd(1, 0, 1, 16'h0000, 2, 0, "add");
    chk("add/result", 32'(tos), 32'h0008);

    // Overflow then undo and re-push.
    cmd(0, 1, 0, 16'h0000, 2, 0, "clr");
    for (int i = 1; i <= 5; i++) cmd(1, 0, 0, 16'(i), 2, 0, $sformatf("fill%0d", i));
    chk("overflow/err", 32'(err), 32'b010);
    cmd(0, 1, 0, 16'h0000, 2, 0, "undo_full");
    chk("undo_full/tos", 32'(tos), 32'd3);
    cmd(1, 0, 0, 16'h0007, 2, 0, "push7");

    // Underflow cases.
    for (int i = 0; i < 3; i++) cmd(0, 1, 0, 16'h0000, 2, 0, "drain");
    cmd(1, 0, 1, 16'h0001, 2, 0, "op_depth1");
    chk("op_depth1/err", 32'(err), 32'b001);
    cmd(0, 1, 0, 16'h0000, 2, 0, "undo_last");
    cmd(0, 1, 0, 16'h0000, 2, 0, "undo_empty");
    chk("undo_empty/err", 32'(err), 32'b001);

    // ALU never answers: timeout leaves operands in place.
    cmd(1, 0, 0, 16'h1234, 2, 0, "pushA");
    cmd(1, 0, 0, 16'h0F0F, 2, 0, "pushB");
    cmd(1, 0, 1, 16'h0002, 0, 0, "timeout");
    chk("timeout/err", 32'(err), 32'b100);

    // Pulses during WAIT are ignored; Enter+Undo together in IDLE is an Undo.
    cmd(1, 0, 1, 16'h0001, 3, 1, "sub_poke");
    cmd(1, 0, 0, 16'h00AA, 2, 0, "pushC");
    cmd(1, 1, 0, 16'h0055, 2, 0, "both");

    // Reset in WAIT; the late alu_done must be ignored.
    cmd(1, 0, 0, 16'h0022, 2, 0, "pushD");
    alu_lat     = 5;
    enter_pulse = 1'b1;
    op_mode     = 1'b1;
    data_in     = 16'h0003;
    tick();
    enter_pulse = 1'b0;
    tick();
    tick();
    chk("rst_mid/status", 32'(status), 32'b100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    m_err = 3'b000;
    for (int i = 0; i < 6; i++) check_idle($sformatf("rst_mid_c%0d", i));
    cmd(1, 0, 0, 16'h0033, 2, 0, "after_rst");

    for (int t = 0; t < 200; t++) begin
      r   = $urandom_range(0, 99);
      lat = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 4);
      if (r < 40)      cmd(1, 0, 0, 16'($urandom), lat, 0, $sformatf("r%0d_push", t));
      else if (r < 72) cmd(1, 0, 1, 16'($urandom), lat, $urandom_range(0, 1) == 1,
                           $sformatf("r%0d_op", t));
      else if (r < 92) cmd(0, 1, 0, 16'($urandom), lat, 0, $sformatf("r%0d_undo", t));
      else             cmd(1, 1, $urandom_range(0, 1) == 1, 16'($urandom), lat, 0,
                           $sformatf("r%0d_both", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
